mm_guess_checker: RTL and testbench

Code-breaker side of the Mastermind machine. Latches the 12-bit secret produced by the code-maker, collects a 4-digit guess (3-bit digits, 0..7) through switch-plus-enter strokes, and scores it as exact hits (right digit, right position) and partial hits (right digit, wrong position). It counts attempts and declares win or lose, feeding the display and turn logic.

---
 rtl/mm_guess_if.sv | 39 +++
 rtl/mm_guess_checker.sv | 179 +++++++++++++++++
 tb/tb_mm_guess_checker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_guess_if.sv
// mm_guess_if
// Bundles the code-breaker's control strobes, guess entry and scoring outputs.
//   master : drives start, code_in, enter, sw; observes status and pegs
//   slave  : the checker; consumes strobes and drives status and pegs
//   start        : one-cycle pulse, latch code_in and begin a game
//   code_in      : 12-bit secret, digit 0 in [11:9] .. digit 3 in [2:0]
//   enter / sw   : one-cycle digit strobe with 3-bit digit value
//   collecting   : checker is accepting guess digits
//   busy         : checker is scoring a guess
//   digit_cnt    : guess digits entered so far this attempt
//   result_valid : one-cycle pulse when pegs/tries update
//   pegs_exact, pegs_partial, tries, win, lose : scoring results
interface mm_guess_if;
  logic        start;
  logic [11:0] code_in;
  logic        enter;
  logic [2:0]  sw;
  logic        collecting;
  logic        busy;
  logic [1:0]  digit_cnt;
  logic        result_valid;
  logic [2:0]  pegs_exact;
  logic [2:0]  pegs_partial;
  logic [3:0]  tries;
  logic        win;
  logic        lose;

  modport master (
    output start, code_in, enter, sw,
    input  collecting, busy, digit_cnt, result_valid,
           pegs_exact, pegs_partial, tries, win, lose
  );

  modport slave (
    input  start, code_in, enter, sw,
    output collecting, busy, digit_cnt, result_valid,
           pegs_exact, pegs_partial, tries, win, lose
  );
endinterface

// File: rtl/mm_guess_checker.sv
// mm_guess_checker
// Code-breaker side of the Mastermind machine. Latches the secret on start,
// collects four 3-bit guess digits through enter strobes, then scores the
// guess: exact hits in one cycle, then eight cycles walking the colours 0..7
// summing min(occurrences in secret, occurrences in guess). Partial hits are
// that sum minus the exact hits. Tracks attempts and sticky win/lose.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : mm_guess_if slave modport (strobes in, status/pegs out)
// Parameter:
//   MAX_TRIES : attempts allowed per game (1..15)
module mm_guess_checker #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset,
  mm_guess_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    EXACT   = 3'd2,
    COUNT   = 3'd3,
    OVER    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] secret;
  logic [11:0] guess;
  logic [1:0]  digit_cnt;
  logic [3:0]  tries;
  logic [2:0]  pegs_exact;
  logic [2:0]  pegs_partial;
  logic        win;
  logic        lose;
  logic        result_valid;
  logic [2:0]  exact;
  logic [2:0]  acc;
  logic [2:0]  c;

  // Occurrences of one colour among the four digits of a code.
  function automatic logic [2:0] count_color(input logic [11:0] code,
                                             input logic [2:0]  color);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (code[i*3 +: 3] == color) n = n + 3'd1;
    return n;
  endfunction

  // Positions where guess and secret carry the same digit.
  function automatic logic [2:0] exact_hits(input logic [11:0] g,
                                            input logic [11:0] s);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (g[i*3 +: 3] == s[i*3 +: 3]) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // Per-colour scoring term for the colour under test this cycle.
  logic [2:0] cs, cg, mn, acc_sum, partial;
  logic       last_color;
  logic       last_try;

  always_comb begin
    cs         = count_color(secret, c);
    cg         = count_color(guess, c);
    mn         = min3(cs, cg);
    acc_sum    = acc + mn;
    // exact never exceeds the colour-match total, so this cannot underflow
    partial    = acc_sum - exact;
    last_color = (c == 3'd7);
    last_try   = ((tries + 4'd1) == 4'(MAX_TRIES));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start overrides everything, including enter.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      COLLECT: if (bus.enter && digit_cnt == 2'd3) state_nxt = EXACT;
      EXACT:   state_nxt = COUNT;
      COUNT: begin
        if (last_color) begin
          if (exact == 3'd4)  state_nxt = OVER;
          else if (last_try)  state_nxt = OVER;
          else                state_nxt = COLLECT;
        end
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
    if (bus.start) state_nxt = COLLECT;
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secret       <= '0;
      guess        <= '0;
      digit_cnt    <= '0;
      tries        <= '0;
      pegs_exact   <= '0;
      pegs_partial <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      result_valid <= 1'b0;
      exact        <= '0;
      acc          <= '0;
      c            <= '0;
    end else begin
      result_valid <= 1'b0;
      if (bus.start) begin
        secret       <= bus.code_in;
        guess        <= '0;
        digit_cnt    <= '0;
        tries        <= '0;
        pegs_exact   <= '0;
        pegs_partial <= '0;
        win          <= 1'b0;
        lose         <= 1'b0;
        exact        <= '0;
        acc          <= '0;
        c            <= '0;
      end else begin
        case (state)
          COLLECT: begin
            if (bus.enter) begin
              guess     <= {guess[8:0], bus.sw};
              digit_cnt <= digit_cnt + 2'd1;  // wraps to 0 on the 4th digit
            end
          end
          EXACT: begin
            exact <= exact_hits(guess, secret);
            acc   <= '0;
            c     <= '0;
          end
          COUNT: begin
            acc <= acc_sum;
            c   <= c + 3'd1;
            if (last_color) begin
              pegs_exact   <= exact;
              pegs_partial <= partial;
              tries        <= tries + 4'd1;
              result_valid <= 1'b1;
              if (exact == 3'd4) win  <= 1'b1;
              else if (last_try) lose <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.collecting   = (state == COLLECT);
  assign bus.busy         = (state == EXACT) || (state == COUNT);
  assign bus.digit_cnt    = digit_cnt;
  assign bus.result_valid = result_valid;
  assign bus.pegs_exact   = pegs_exact;
  assign bus.pegs_partial = pegs_partial;
  assign bus.tries        = tries;
  assign bus.win          = win;
  assign bus.lose         = lose;

endmodule

// File: tb/tb_mm_guess_checker.sv
// tb_mm_guess_checker
// Directed bench for mm_guess_checker built with MAX_TRIES = 2.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_mm_guess_checker;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mm_guess_if bus ();

  mm_guess_checker #(.MAX_TRIES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [11:0] code);
    @(negedge clk);
    bus.code_in = code;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic pulse_enter(input logic [2:0] d);
    @(negedge clk);
    bus.sw    = d;
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  // Four back-to-back enters; returns on the falling edge just after E0.
  task automatic enter_code(input logic [11:0] g);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      bus.sw    = g[i*3 +: 3];
      bus.enter = 1'b1;
    end
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  // Enter a guess, check busy window and 9-cycle result latency.
  task automatic run_guess(input string tag, input logic [11:0] g);
    int lat;
    enter_code(g);
    check_eq({tag, "_busy"}, bus.busy, 1);
    check_eq({tag, "_coll"}, bus.collecting, 0);
    lat = 0;
    while (!bus.result_valid && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 9);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.code_in  = '0;
    bus.enter    = 1'b0;
    bus.sw       = '0;
    #12;
    check_eq("rst_coll", bus.collecting, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rv", bus.result_valid, 0);
    check_eq("rst_tries", bus.tries, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-COLLECT with two digits entered
    do_start(12'o1234);
    check_eq("c_coll", bus.collecting, 1);
    pulse_enter(3'd1);
    pulse_enter(3'd2);
    check_eq("c_dcnt2", bus.digit_cnt, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("r_dcnt", bus.digit_cnt, 0);
    check_eq("r_coll", bus.collecting, 0);
    @(negedge clk);
    reset = 1'b0;
    pulse_enter(3'd5);
    check_eq("idle_enter_dcnt", bus.digit_cnt, 0);
    check_eq("idle_enter_coll", bus.collecting, 0);

    // Exact win
    do_start(12'o1234);
    run_guess("win", 12'o1234);
    check_eq("win_ex", bus.pegs_exact, 4);
    check_eq("win_pa", bus.pegs_partial, 0);
    check_eq("win_tries", bus.tries, 1);
    check_eq("win_win", bus.win, 1);
    check_eq("win_lose", bus.lose, 0);
    @(negedge clk);
    check_eq("win_rv_1cyc", bus.result_valid, 0);
    pulse_enter(3'd3);
    check_eq("win_ign_dcnt", bus.digit_cnt, 0);
    check_eq("win_ign_tries", bus.tries, 1);

    // Permutation
    do_start(12'o1234);
    check_eq("perm_clr_win", bus.win, 0);
    run_guess("perm", 12'o4321);
    check_eq("perm_ex", bus.pegs_exact, 0);
    check_eq("perm_pa", bus.pegs_partial, 4);
    check_eq("perm_tries", bus.tries, 1);
    @(negedge clk);
    check_eq("perm_coll", bus.collecting, 1);

    // Duplicates (second attempt is also the last with MAX_TRIES=2)
    do_start(12'o1123);
    run_guess("dup1", 12'o1111);
    check_eq("dup1_ex", bus.pegs_exact, 2);
    check_eq("dup1_pa", bus.pegs_partial, 0);
    run_guess("dup2", 12'o3311);
    check_eq("dup2_ex", bus.pegs_exact, 0);
    check_eq("dup2_pa", bus.pegs_partial, 3);
    check_eq("dup2_tries", bus.tries, 2);
    check_eq("dup2_lose", bus.lose, 1);

    // Lose
    do_start(12'o7777);
    run_guess("lose1", 12'o0000);
    check_eq("lose1_tries", bus.tries, 1);
    check_eq("lose1_lose", bus.lose, 0);
    run_guess("lose2", 12'o0000);
    check_eq("lose2_lose", bus.lose, 1);
    check_eq("lose2_win", bus.win, 0);
    check_eq("lose2_tries", bus.tries, 2);
    pulse_enter(3'd7);
    check_eq("over_dcnt", bus.digit_cnt, 0);
    check_eq("over_coll", bus.collecting, 0);
    check_eq("over_tries", bus.tries, 2);
    do_start(12'o7777);
    check_eq("restart_tries", bus.tries, 0);
    check_eq("restart_lose", bus.lose, 0);
    check_eq("restart_coll", bus.collecting, 1);

    // start and enter together mid-COLLECT: start wins, new code latched
    do_start(12'o1234);
    pulse_enter(3'd1);
    pulse_enter(3'd2);
    @(negedge clk);
    bus.code_in = 12'o5670;
    bus.start   = 1'b1;
    bus.enter   = 1'b1;
    bus.sw      = 3'd3;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.enter   = 1'b0;
    check_eq("prio_dcnt", bus.digit_cnt, 0);
    check_eq("prio_coll", bus.collecting, 1);
    run_guess("prio", 12'o5670);
    check_eq("prio_ex", bus.pegs_exact, 4);
    check_eq("prio_win", bus.win, 1);

    // Reset during COUNT: no result ever appears
    do_start(12'o1234);
    enter_code(12'o1234);
    repeat (3) @(negedge clk);
    check_eq("cnt_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_eq("cnt_rst_busy", bus.busy, 0);
    check_eq("cnt_rst_ex", bus.pegs_exact, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.result_valid) seen++;
      end
      check_eq("cnt_rst_norv", seen, 0);
    end
    check_eq("cnt_rst_tries", bus.tries, 0);
    check_eq("cnt_rst_win", bus.win, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
